// File: rtl/processor_control_if.sv
// Decoder bus for processor_control: the instruction word in, the datapath
// control flags out. The slave modport is the decoder side.
interface processor_control_if;
  logic [31:0] instruction;
  logic        regWriteFlag;
  logic [2:0]  opType;
  logic        memWriteFlag;
  logic        memReadFlag;
  logic [3:0]  aluControlCode;
  logic        branchFlag;
  logic        unconditionalBranchFlag;
  logic        aluSRC;

  modport slave (
    input  instruction,
    output regWriteFlag, opType, memWriteFlag, memReadFlag,
           aluControlCode, branchFlag, unconditionalBranchFlag, aluSRC
  );

  modport master (
    output instruction,
    input  regWriteFlag, opType, memWriteFlag, memReadFlag,
           aluControlCode, branchFlag, unconditionalBranchFlag, aluSRC
  );
endinterface

// File: rtl/processor_control.sv
// Registered main-control decoder for the ARM-LP core: classifies each
// instruction word by opcode bits and registers the datapath control flags.
module processor_control (
  input  logic               clk,
  input  logic               reset,
  processor_control_if.slave ctrl
);

  localparam logic [2:0] OP_R   = 3'd0;
  localparam logic [2:0] OP_I   = 3'd1;
  localparam logic [2:0] OP_D   = 3'd2;
  localparam logic [2:0] OP_B   = 3'd3;
  localparam logic [2:0] OP_CB  = 3'd4;
  localparam logic [2:0] OP_IW  = 3'd5;
  localparam logic [2:0] OP_NOP = 3'd7;

  // Function field F = instruction[31:29] selects the ALU operation for R/I forms.
  function automatic logic [3:0] funcCode(input logic [2:0] f);
    logic [3:0] code;
    case (f)
      3'b000:  code = 4'd2;
      3'b001:  code = 4'd10;
      3'b010:  code = 4'd6;
      3'b011:  code = 4'd4;
      3'b100:  code = 4'd9;
      3'b101:  code = 4'd5;
      3'b110:  code = 4'd12;
      3'b111:  code = 4'd13;
      default: code = 4'd0;
    endcase
    return code;
  endfunction

  logic       regWrite_s;
  logic       memWrite_s;
  logic       memRead_s;
  logic       branch_s;
  logic       uncondBranch_s;
  logic       aluSrc_s;
  logic [3:0] aluCode_s;
  logic [2:0] opType_s;
  logic [2:0] func_s;
  logic       unusedBits_s;

  assign func_s       = ctrl.instruction[31:29];
  assign unusedBits_s = ^{ctrl.instruction[25:24], ctrl.instruction[21:0]};

  // Priority decode: branches first (bits 27/28 ignored), then store/R, then load/MOV/I.
  always_comb begin
    regWrite_s     = 1'b0;
    memWrite_s     = 1'b0;
    memRead_s      = 1'b0;
    branch_s       = 1'b0;
    uncondBranch_s = 1'b0;
    aluSrc_s       = 1'b0;
    aluCode_s      = 4'd0;
    opType_s       = OP_NOP;
    if (ctrl.instruction[26]) begin
      if (ctrl.instruction[29]) begin
        branch_s  = 1'b1;
        aluCode_s = 4'd7;
        opType_s  = OP_CB;
      end else begin
        uncondBranch_s = 1'b1;
        opType_s       = OP_B;
      end
    end else if (ctrl.instruction[27]) begin
      if (ctrl.instruction[28]) begin
        memWrite_s = 1'b1;
        aluSrc_s   = 1'b1;
        aluCode_s  = 4'd2;
        opType_s   = OP_D;
      end else begin
        regWrite_s = 1'b1;
        aluCode_s  = funcCode(func_s);
        opType_s   = OP_R;
      end
    end else if (ctrl.instruction[28]) begin
      regWrite_s = 1'b1;
      aluSrc_s   = 1'b1;
      // Load outranks MOV when both b22 and b23 are set.
      if (ctrl.instruction[22]) begin
        memRead_s = 1'b1;
        aluCode_s = 4'd2;
        opType_s  = OP_D;
      end else if (ctrl.instruction[23]) begin
        aluCode_s = 4'd13;
        opType_s  = OP_IW;
      end else begin
        aluCode_s = funcCode(func_s);
        opType_s  = OP_I;
      end
    end else begin
      opType_s = OP_NOP;
    end
  end

  // Output register; reset forces the invalid/NOP decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl.regWriteFlag            <= 1'b0;
      ctrl.memWriteFlag            <= 1'b0;
      ctrl.memReadFlag             <= 1'b0;
      ctrl.branchFlag              <= 1'b0;
      ctrl.unconditionalBranchFlag <= 1'b0;
      ctrl.aluSRC                  <= 1'b0;
      ctrl.aluControlCode          <= 4'd0;
      ctrl.opType                  <= OP_NOP;
    end else begin
      ctrl.regWriteFlag            <= regWrite_s;
      ctrl.memWriteFlag            <= memWrite_s;
      ctrl.memReadFlag             <= memRead_s;
      ctrl.branchFlag              <= branch_s;
      ctrl.unconditionalBranchFlag <= uncondBranch_s;
      ctrl.aluSRC                  <= aluSrc_s;
      ctrl.aluControlCode          <= aluCode_s;
      ctrl.opType                  <= opType_s;
    end
  end

endmodule

// File: tb/tb_processor_control.sv
// Self-checking bench for processor_control: directed vectors with literal
// expectations plus a per-cycle compare against a class-table model.
module tb_processor_control;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  processor_control_if intf ();

  processor_control dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (intf.slave)
  );

  always #5 clk = ~clk;

  // Packed view: {rw, mw, mr, br, ub, src, alu[3:0], op[2:0]}
  function automatic logic [12:0] mk(input logic rw, input logic mw, input logic mr,
                                     input logic br, input logic ub, input logic src,
                                     input logic [3:0] alu, input logic [2:0] op);
    return {rw, mw, mr, br, ub, src, alu, op};
  endfunction

  function automatic logic [12:0] dutOut();
    return {intf.regWriteFlag, intf.memWriteFlag, intf.memReadFlag, intf.branchFlag,
            intf.unconditionalBranchFlag, intf.aluSRC, intf.aluControlCode, intf.opType};
  endfunction

  typedef enum int {C_CB, C_B, C_ST, C_R, C_LD, C_MOV, C_I, C_INV} cls_t;

  // Model: identify the instruction class, then look up that class's outputs.
  function automatic logic [12:0] model(input logic [31:0] w);
    logic [3:0] fTab [8];
    cls_t c;
    fTab = '{4'd2, 4'd10, 4'd6, 4'd4, 4'd9, 4'd5, 4'd12, 4'd13};
    if (w[26])      c = w[29] ? C_CB : C_B;
    else if (w[27]) c = w[28] ? C_ST : C_R;
    else if (w[28]) c = w[22] ? C_LD : (w[23] ? C_MOV : C_I);
    else            c = C_INV;
    case (c)
      C_CB:    return mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd7, 3'd4);
      C_B:     return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 3'd3);
      C_ST:    return mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 3'd2);
      C_R:     return mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, fTab[w[31:29]], 3'd0);
      C_LD:    return mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 3'd2);
      C_MOV:   return mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd13, 3'd5);
      C_I:     return mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, fTab[w[31:29]], 3'd1);
      default: return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 3'd7);
    endcase
  endfunction

  logic [12:0] RST_VAL;
  logic [12:0] expR;
  logic        expValid = 1'b0;
  logic        running  = 1'b1;

  initial RST_VAL = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 3'd7);

  // Scoreboard: expected outputs after each edge.
  always @(posedge clk) begin
    expR     <= reset ? RST_VAL : model(intf.instruction);
    expValid <= 1'b1;
  end

  // Per-cycle compare on the falling edge.
  always @(negedge clk) begin
    if (expValid && running) begin
      tests++;
      if (dutOut() !== expR) begin
        fails++;
        $display("FAIL model_cmp t=%0t got %h want %h (instr %h)", $time, dutOut(), expR,
                 intf.instruction);
      end
    end
  end

  task automatic checkLit(input string name, input logic [12:0] want);
    tests++;
    if (dutOut() !== want) begin
      fails++;
      $display("FAIL %s got %h want %h", name, dutOut(), want);
    end
  endtask

  task automatic drive(input logic [31:0] w);
    intf.instruction = w;
    @(posedge clk);
    #1;
  endtask

  logic [12:0] LD, CB, R0, ST, I0, B0, MV, NOP;
  logic [31:0] seqW [7];
  logic [12:0] seqE [7];
  string       seqN [7];

  initial begin
    LD  = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 3'd2);
    CB  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd7, 3'd4);
    R0  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 3'd0);
    ST  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 3'd2);
    I0  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 3'd1);
    B0  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 3'd3);
    MV  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd13, 3'd5);
    NOP = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 3'd7);

    reset = 1'b1;
    drive(32'h1040_0000);
    checkLit("reset_c1", NOP);
    drive(32'h1040_0000);
    checkLit("reset_c2", NOP);
    reset = 1'b0;
    drive(32'h1040_0000);
    checkLit("post_reset_load", LD);

    drive(32'h2400_0000); checkLit("cb", CB);
    drive(32'h0800_0000); checkLit("r_add", R0);
    drive(32'h2800_0000); checkLit("r_sub", mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd10, 3'd0));
    drive(32'hE800_0000); checkLit("r_mov", mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd13, 3'd0));
    drive(32'h1800_0000); checkLit("store", ST);
    drive(32'h1000_0000); checkLit("i_add", I0);
    drive(32'h5000_0000); checkLit("i_and", mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd6, 3'd1));
    drive(32'h0400_0000); checkLit("b", B0);
    drive(32'h1080_0000); checkLit("mov", MV);
    drive(32'h1C00_0000); checkLit("prio_b_over_st", B0);
    drive(32'h10C0_0000); checkLit("prio_ld_over_mov", LD);
    drive(32'h0000_0000); checkLit("invalid", NOP);
    drive(32'h3C00_0000); checkLit("prio_cb_ignores_27_28", CB);
    drive(32'hB000_0000); checkLit("i_nor", mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 3'd1));

    // Reset asserted mid-stream overrides a valid word.
    reset = 1'b1;
    drive(32'h0800_0000); checkLit("reset_priority", NOP);
    reset = 1'b0;

    // Back-to-back sequence, one word per cycle.
    seqW = '{32'h1040_0000, 32'h2400_0000, 32'h0800_0000, 32'h1800_0000,
             32'h1000_0000, 32'h0400_0000, 32'h1080_0000};
    seqE = '{LD, CB, R0, ST, I0, B0, MV};
    seqN = '{"seq_ld", "seq_cb", "seq_r", "seq_st", "seq_i", "seq_b", "seq_mov"};
    for (int i = 0; i < 7; i++) begin
      drive(seqW[i]);
      checkLit(seqN[i], seqE[i]);
    end

    // Sweep of function fields across R and I forms for the model compare.
    for (int f = 0; f < 8; f++) begin
      logic [2:0] ff;
      ff = f[2:0];
      drive({ff, 29'h0800_0000});
      drive({ff, 29'h1000_0000});
    end

    @(negedge clk);
    running = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
